// File: rtl/jtpang_pcm_rom.sv
`default_nettype none
// ============================================================================
// Module   : jtpang_pcm_rom
// Purpose  : Byte-wide PCM sample ROM front-end over a 16-bit SDRAM port.
//            Two direct-mapped word entries; demand fetch on miss and an
//            optional prefetch of the next sequential word.
// Revision : 1.0 - initial release
// ============================================================================
module jtpang_pcm_rom #(
  parameter int AW       = 18,
  parameter bit PREFETCH = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] rom_addr,
  output logic [7:0]    rom_data,
  output logic          rom_ok,
  output logic [AW-2:0] sdram_addr,
  output logic          sdram_req,
  input  logic          sdram_ack,
  input  logic          sdram_valid,
  input  logic [15:0]   sdram_data
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    valid_q, valid_d;
  logic          demand_q, demand_d;
  logic          req_q, req_d;
  logic [AW-2:0] sdram_addr_q, sdram_addr_d;
  logic [AW-2:0] tag_q  [2];
  logic [15:0]   word_q [2];

  logic [AW-2:0] cur_word;
  logic [AW-2:0] nxt_word;
  logic          sel;
  logic          hit;
  logic          nxt_held;
  logic          fill_en;

  assign cur_word = rom_addr[AW-1:1];
  assign nxt_word = cur_word + (AW-1)'(1);  // wraps naturally at the top word
  assign sel      = rom_addr[1];

  // Lookup of the current address and of its sequential successor
  always_comb begin
    hit      = valid_q[sel] && (tag_q[sel] == cur_word);
    nxt_held = valid_q[nxt_word[0]] && (tag_q[nxt_word[0]] == nxt_word);
    rom_ok   = hit;
    rom_data = rom_addr[0] ? word_q[sel][15:8] : word_q[sel][7:0];
  end

  // Fetch controller next-state: demand misses win over prefetch
  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    demand_d     = demand_q;
    sdram_addr_d = sdram_addr_q;
    fill_en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!hit) begin
          state_d      = ST_REQ;
          sdram_addr_d = cur_word;
          demand_d     = 1'b1;
          valid_d[sel] = 1'b0;
        end else if (PREFETCH && !nxt_held) begin
          state_d              = ST_REQ;
          sdram_addr_d         = nxt_word;
          demand_d             = 1'b0;
          valid_d[nxt_word[0]] = 1'b0;
        end
      end
      ST_REQ: begin
        if (sdram_ack) begin
          if (sdram_valid) begin
            fill_en = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (sdram_valid) begin
          fill_en = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (fill_en) begin
      valid_d[sdram_addr_q[0]] = 1'b1;
      demand_d                 = 1'b0;
    end
    req_d = (state_d == ST_REQ);
  end

  // Controller state and valid bits, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      valid_q      <= 2'b00;
      demand_q     <= 1'b0;
      req_q        <= 1'b0;
      sdram_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      demand_q     <= demand_d;
      req_q        <= req_d;
      sdram_addr_q <= sdram_addr_d;
    end
  end

  // Entry payload; contents are meaningless while the valid bit is low
  always_ff @(posedge clk) begin
    if (fill_en && !rst) begin
      tag_q[sdram_addr_q[0]]  <= sdram_addr_q;
      word_q[sdram_addr_q[0]] <= sdram_data;
    end
  end

  assign sdram_req  = req_q;
  assign sdram_addr = sdram_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_jtpang_pcm_rom.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtpang_pcm_rom
// Purpose  : Randomized bench for jtpang_pcm_rom, PREFETCH=1 and PREFETCH=0
//            instances side by side, against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jtpang_pcm_rom;

  logic             clk = 1'b0;
  logic             rst;
  logic [17:0]      rom_addr;
  logic [1:0][7:0]  rom_data;
  logic [1:0]       rom_ok;
  logic [1:0][16:0] s_addr;
  logic [1:0]       s_req;
  logic [1:0]       s_ack;
  logic [1:0]       s_valid;
  logic [1:0][15:0] s_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  jtpang_pcm_rom #(.AW(18), .PREFETCH(1'b1)) dut_pf (
    .clk(clk), .rst(rst), .rom_addr(rom_addr),
    .rom_data(rom_data[0]), .rom_ok(rom_ok[0]),
    .sdram_addr(s_addr[0]), .sdram_req(s_req[0]),
    .sdram_ack(s_ack[0]), .sdram_valid(s_valid[0]), .sdram_data(s_data[0])
  );

  jtpang_pcm_rom #(.AW(18), .PREFETCH(1'b0)) dut_np (
    .clk(clk), .rst(rst), .rom_addr(rom_addr),
    .rom_data(rom_data[1]), .rom_ok(rom_ok[1]),
    .sdram_addr(s_addr[1]), .sdram_req(s_req[1]),
    .sdram_ack(s_ack[1]), .sdram_valid(s_valid[1]), .sdram_data(s_data[1])
  );

  // Backing ROM: lazily filled with random words, some preset
  logic [15:0] mem [int];

  function automatic logic [15:0] memrd(input logic [16:0] w);
    if (!mem.exists(int'(w))) mem[int'(w)] = 16'($urandom);
    return mem[int'(w)];
  endfunction

  // Model: per instance, outstanding-fetch phase (0 none, 1 requesting,
  // 2 accepted) and which words the two slots currently hold
  int          ph    [2];
  bit          mv    [2][2];
  logic [16:0] mt    [2][2];
  logic [16:0] maddr [2];
  bit          pf    [2];

  function automatic bit mholds(input int d, input logic [16:0] w);
    return mv[d][w[0]] && (mt[d][w[0]] == w);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_fill(input int d);
    mv[d][maddr[d][0]] = 1'b1;
    mt[d][maddr[d][0]] = maddr[d];
    ph[d] = 0;
  endtask

  task automatic model_step(input int d);
    logic [16:0] w;
    logic [16:0] n;
    w = rom_addr[17:1];
    n = w + 17'd1;
    if (rst) begin
      ph[d] = 0; mv[d][0] = 1'b0; mv[d][1] = 1'b0; maddr[d] = '0;
    end else if (ph[d] == 0) begin
      if (!mholds(d, w)) begin
        ph[d] = 1; maddr[d] = w; mv[d][w[0]] = 1'b0;
      end else if (pf[d] && !mholds(d, n)) begin
        ph[d] = 1; maddr[d] = n; mv[d][n[0]] = 1'b0;
      end
    end else if (ph[d] == 1) begin
      if (s_ack[d]) begin
        if (s_valid[d]) model_fill(d);
        else ph[d] = 2;
      end
    end else begin
      if (s_valid[d]) model_fill(d);
    end
  endtask

  task automatic check_outputs(input int d);
    logic [16:0] w;
    logic [15:0] mw;
    logic        exp_ok;
    logic [7:0]  exp_b;
    w      = rom_addr[17:1];
    exp_ok = mholds(d, w);
    check($sformatf("req%0d", d), 32'(s_req[d]), 32'(ph[d] == 1));
    check($sformatf("saddr%0d", d), 32'(s_addr[d]), 32'(maddr[d]));
    check($sformatf("ok%0d", d), 32'(rom_ok[d]), 32'(exp_ok));
    if (exp_ok) begin
      mw    = memrd(w);
      exp_b = rom_addr[0] ? mw[15:8] : mw[7:0];
      check($sformatf("data%0d", d), 32'(rom_data[d]), 32'(exp_b));
    end
  endtask

  task automatic drive_sdram(input int d);
    s_ack[d]   = 1'b0;
    s_valid[d] = 1'b0;
    if (ph[d] == 1) begin
      s_ack[d] = ($urandom_range(0, 1) == 0);
      if (s_ack[d] && $urandom_range(0, 3) == 0) s_valid[d] = 1'b1;
    end else if (ph[d] == 2) begin
      s_valid[d] = ($urandom_range(0, 2) == 0);
    end else begin
      s_ack[d]   = ($urandom_range(0, 19) == 0);
      s_valid[d] = ($urandom_range(0, 19) == 0);
    end
    if (rst) s_valid[d] = ($urandom_range(0, 2) == 0);
    s_data[d] = (s_valid[d] && ph[d] != 0 && !rst) ? memrd(maddr[d]) : 16'($urandom);
  endtask

  initial begin
    int rst_cnt;
    logic [17:0] a;
    pf[0] = 1'b1;
    pf[1] = 1'b0;
    mem[2]       = 16'hA1B2;
    mem[3]       = 16'h1234;
    mem[17'h8000] = 16'h5AC3;
    rst      = 1'b1;
    rom_addr = 18'h00005;
    s_ack    = '0;
    s_valid  = '0;
    s_data   = '0;
    for (int d = 0; d < 2; d++) model_step(d);
    repeat (3) @(posedge clk);
    rst_cnt = 0;
    a = 18'h00005;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) check_outputs(d);
      // Address schedule: cold miss/prefetch, neighbour hit, wrap, collision
      if (c < 40)       a = 18'h00005;
      else if (c < 70)  a = 18'h00006;
      else if (c < 110) a = 18'h3FFFF;
      else if (c < 150) a = 18'h10000;
      else begin
        case ($urandom_range(0, 9))
          0:          a = 18'($urandom);
          1:          a = 18'h3FFFC + 18'($urandom_range(0, 3));
          2, 3, 4:    a = a + 18'd1;
          default:    a = a;
        endcase
      end
      rom_addr = a;
      if (rst_cnt > 0) rst_cnt--;
      else if (c > 150 && $urandom_range(0, 399) == 0) rst_cnt = 2;
      rst = (rst_cnt > 0);
      for (int d = 0; d < 2; d++) drive_sdram(d);
      for (int d = 0; d < 2; d++) model_step(d);
    end
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/jtpang_pcm_rom.md
JTPANG_PCM_ROM -- requirements
Module: jtpang_pcm_rom

Interface
REQ-001 The block SHALL have parameter AW, default 18, meaning byte-address width of the PCM sample ROM port.
REQ-002 The block SHALL have parameter PREFETCH, default 1, meaning 1 enables next-word prefetch and 0 disables it.
REQ-003 Port clk, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous to clk, active-high.
REQ-005 Port rom_addr, input, AW bits: byte address requested by the ADPCM decoder.
REQ-006 Port rom_data, output, 8 bits: byte at rom_addr; valid only while rom_ok=1.
REQ-007 Port rom_ok, output, 1 bit: rom_data matches the current rom_addr.
REQ-008 Port sdram_addr, output, AW-1 bits: 16-bit word address of the outstanding fetch.
REQ-009 Port sdram_req, output, 1 bit: fetch request, held until acknowledged.
REQ-010 Port sdram_ack, input, 1 bit: one-cycle pulse; the request is accepted.
REQ-011 Port sdram_valid, input, 1 bit: one-cycle pulse; sdram_data holds the fetched word.
REQ-012 Port sdram_data, input, 16 bits: fetched word; low byte = even address, high byte = odd address.

Function
REQ-013 Storage SHALL be two entries, each holding {valid, tag[AW-2:0], word[15:0]}; a word address W maps to entry W[0] (direct-mapped).
REQ-014 Hit SHALL mean entry rom_addr[1] is valid and its tag equals rom_addr[AW-1:1].
REQ-015 rom_ok SHALL be combinational from registered state: 1 on hit, else 0; rom_data SHALL be word[15:8] when rom_addr[0]=1, else word[7:0], of the selected entry.
REQ-016 The controller SHALL be an FSM with states IDLE, REQ, WAIT; sdram_req=1 only in REQ.
REQ-017 IDLE and miss: next cycle enter REQ with sdram_addr=rom_addr[AW-1:1] and a demand flag set.
REQ-018 IDLE, hit, PREFETCH=1, and entry for word N=rom_addr[AW-1:1]+1 (mod 2^(AW-1)) does not hold N: next cycle enter REQ with sdram_addr=N, demand flag clear.
REQ-019 IDLE otherwise: remain in IDLE, sdram_req=0.
REQ-020 REQ: sdram_addr and sdram_req SHALL stay constant until sdram_ack=1, then enter WAIT the next cycle.
REQ-021 WAIT: on sdram_valid=1, write sdram_data, tag=sdram_addr and valid=1 into entry sdram_addr[0], and return to IDLE the next cycle.
REQ-022 If sdram_ack and sdram_valid are both 1 in the same REQ cycle, the block SHALL accept both, fill the entry, and go directly to IDLE.
REQ-023 An in-flight fetch SHALL never be aborted by rom_addr changes; a demand miss arising during a prefetch SHALL be issued after that prefetch fills (demand has priority on the next IDLE evaluation).
REQ-024 The entry being filled SHALL have valid cleared on the cycle the fetch is issued, so rom_ok cannot report stale data for it.
REQ-025 Miss latency: with sdram_ack the cycle after sdram_req rises and sdram_valid k cycles later, rom_ok SHALL rise k+3 cycles after rom_addr changes to a missing address.
REQ-026 Word address wrap: prefetch of word 2^(AW-1)-1 successor SHALL target word 0.
REQ-027 sdram_ack or sdram_valid pulses in IDLE SHALL be ignored.

Reset
REQ-028 While rst=1: state=IDLE, both valid bits=0, demand flag=0, sdram_req=0, sdram_addr=0, rom_ok=0, entry word contents don't-care.
REQ-029 Reset asserted mid-fetch SHALL drop sdram_req the next cycle; a subsequent late sdram_valid SHALL be ignored (REQ-027).

Verification
REQ-030 Cold miss: reset, rom_addr=0x00005, ack 1 cycle after req, valid 2 cycles after ack with data 0xA1B2 -> sdram_addr=0x00002, rom_ok=1, rom_data=0xA1.
REQ-031 Prefetch: after REQ-030, hold address -> second request sdram_addr=0x00003; then rom_addr=0x00006 hits with no new demand request and rom_ok stays 1 once filled.
REQ-032 Collision: rom_addr changes to 0x10000 during prefetch WAIT -> prefetch completes first, then demand request sdram_addr=0x08000, rom_ok=0 until it fills.
REQ-033 Wrap: rom_addr=0x3FFFF hit, PREFETCH=1 -> prefetch sdram_addr=0x00000; PREFETCH=0 -> no request.
REQ-034 Same-cycle ack+valid: ack and valid both pulsed in REQ with 0x1234 -> entry filled, state IDLE next cycle, rom_addr even -> rom_data=0x34.
REQ-035 Reset mid-WAIT, then sdram_valid pulse -> sdram_req=0, rom_ok=0, no entry becomes valid.
